// File: rtl/counter_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : counter_sched                                          |
// | Description : One preset-loadable W-bit up-counter time-shared among |
// |               N_REQ requesters with round-robin arbitration. Each    |
// |               grant runs an interval of len cycles, then pulses ack. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module counter_sched #(
  parameter int W     = 16,
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] len,
  input  logic               abort,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [W-1:0]       cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [IW:0]   N_WIDE   = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [W-1:0]     cnt_nx;
  logic [N_REQ-1:0] gnt_nx;
  // last doubles as the owner index: it is updated to the winner on entry
  // to LOAD and is kept on abort, so it always names the current owner.
  logic [IW-1:0]    last, last_nx;
  logic [W-1:0]     len_arr [N_REQ];
  logic [W-1:0]     owner_len;
  logic [IW-1:0]    win;
  logic             found;
  logic [IW:0]      probe;

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_len
      assign len_arr[g] = len[g*W +: W];
    end
  endgenerate

  assign owner_len = len_arr[last];

  // Round-robin search starting one past the previous owner, wrapping at N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    probe = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      probe = {1'b0, last} + (IW+1)'(i);
      if (probe >= N_WIDE) probe = probe - N_WIDE;
      if (!found && req[probe[IW-1:0]]) begin
        found = 1'b1;
        win   = probe[IW-1:0];
      end
    end
  end

  // Next-state, counter and grant logic; abort only acts in LOAD and COUNT.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = LOAD;
          gnt_nx   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          last_nx  = win;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
          gnt_nx   = '0;
        end else begin
          // Preset so that exactly len increments reach the wrap to zero.
          cnt_nx   = '0 - owner_len;
          state_nx = (owner_len != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nx = IDLE;
          gnt_nx   = '0;
        end else begin
          cnt_nx = cnt + W'(1);
          if (cnt == '1) state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      gnt   <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
    end
  end

  assign busy = (state != IDLE);
  assign ack  = (state == DONE) ? gnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_counter_sched                                       |
// | Description : Scoreboard bench for counter_sched: directed scenarios |
// |               plus randomized round-robin traffic with aborts.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_counter_sched;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*W-1:0] len;
  logic          abort;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic          busy;
  logic [W-1:0]  cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] who;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  counter_sched #(.W(W), .N_REQ(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .abort (abort),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(logic [N-1:0] who, int c);
    exp_t e;
    e.who = who;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_len(int i, logic [W-1:0] v);
    len[i*W +: W] = v;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic scramble;
    req = N'($urandom);
    len = {$urandom(), $urandom()};
  endtask

  // Round-robin rule: first requester found scanning from previous owner + 1.
  function automatic int rr_pick(int lst, logic [N-1:0] m);
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (lst + 1 + j) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: every ack pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_who", 32'(ack), 32'(mon_e.who));
        check("ack_cycle", cyc, mon_e.cyc);
        check("ack_cnt", 32'(cnt), 32'd0);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int mlast;
    int w;
    int lv;
    int k;
    logic [N-1:0] mask;
    logic do_abort;

    rst   = 1'b0;
    req   = '0;
    len   = '0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b1;

    // Single grant, len=3: counter walks FFFD..0000.
    req = 4'b0001;
    set_len(0, 16'd3);
    tick;
    e0 = cyc;
    check("s1_gnt", 32'(gnt), 32'h1);
    check("s1_busy", 32'(busy), 32'd1);
    expect_ack(4'b0001, e0 + 4);
    req = '0;
    tick; check("s1_cnt0", 32'(cnt), 32'hFFFD);
    tick; check("s1_cnt1", 32'(cnt), 32'hFFFE);
    tick; check("s1_cnt2", 32'(cnt), 32'hFFFF);
    tick; check("s1_cnt3", 32'(cnt), 32'h0000);
    check("s1_ack", 32'(ack), 32'h1);
    tick;
    check("s1_gnt_clr", 32'(gnt), 32'd0);
    check("s1_busy_clr", 32'(busy), 32'd0);

    // Zero-length interval goes LOAD -> DONE.
    req = 4'b0010;
    set_len(1, 16'd0);
    tick;
    e0 = cyc;
    check("s2_gnt", 32'(gnt), 32'h2);
    expect_ack(4'b0010, e0 + 1);
    req = '0;
    tick;
    check("s2_cnt", 32'(cnt), 32'd0);
    check("s2_busy", 32'(busy), 32'd1);
    tick;
    check("s2_idle", 32'(busy), 32'd0);

    // All requesting with len=1: rotation from reset, one grant every 4 cycles.
    do_reset;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_len(i, 16'd1);
    tick;
    e0 = cyc;
    check("s3_gnt", 32'(gnt), 32'h1);
    for (int j = 0; j < 5; j++) expect_ack(4'b0001 << (j % N), e0 + 4*j + 2);
    repeat (19) tick;
    req = '0;

    // Abort in the 4th COUNT cycle; next grant goes to requester 1.
    do_reset;
    req = 4'b0011;
    set_len(0, 16'd10);
    set_len(1, 16'd2);
    tick;
    check("s4_gnt", 32'(gnt), 32'h1);
    tick; tick; tick; tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_gnt_clr", 32'(gnt), 32'd0);
    check("s4_cnt_hold", 32'(cnt), 32'hFFF9);
    tick;
    e0 = cyc;
    check("s4_gnt_next", 32'(gnt), 32'h2);
    expect_ack(4'b0010, e0 + 3);
    req = '0;
    repeat (4) tick;

    // Reset mid-COUNT clears outputs immediately and discards the interval.
    req = 4'b0001;
    set_len(0, 16'd5);
    tick;
    req = '0;
    tick;
    tick;
    #2;
    rst = 1'b0;
    #1;
    check("s5_gnt", 32'(gnt), 32'd0);
    check("s5_ack", 32'(ack), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) tick;

    // Randomized traffic against the round-robin reference model.
    mlast = N - 1;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) tick;
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_len(i, W'($urandom_range(0, 6)));
      w     = rr_pick(mlast, mask);
      lv    = int'(len[w*W +: W]);
      mlast = w;
      do_abort = ($urandom_range(0, 3) == 0);
      req   = mask;
      abort = do_abort ? 1'b0 : 1'($urandom_range(0, 1));
      tick;
      abort = 1'b0;
      e0 = cyc;
      check("rnd_gnt", 32'(gnt), 32'(1) << w);
      if (do_abort) begin
        k = $urandom_range(1, lv + 1);
        for (int s = 1; s < k; s++) begin
          tick;
          scramble;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("rnd_abort_busy", 32'(busy), 32'd0);
        check("rnd_abort_gnt", 32'(gnt), 32'd0);
      end else begin
        expect_ack(N'(1) << w, e0 + lv + 1);
        tick;
        scramble;
        repeat (lv) tick;
        abort = 1'($urandom_range(0, 1));
        tick;
        abort = 1'b0;
      end
    end
    req = '0;
    tick;

    // Full-range interval: 65535 COUNT cycles before the single ack.
    req = 4'b0001;
    set_len(0, 16'hFFFF);
    tick;
    e0 = cyc;
    expect_ack(4'b0001, e0 + 65536);
    req = '0;
    tick;
    check("s6_cnt_load", 32'(cnt), 32'h1);
    repeat (65535) tick;
    check("s6_gnt_done", 32'(gnt), 32'h1);
    tick;
    check("s6_idle", 32'(busy), 32'd0);

    repeat (4) tick;
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
